port_actuation_sequencer: RTL

//   Off-chip controller that drives the 4x8 fluidic port grid (port_<row>_<col>) of a chip top.

---
 rtl/port_actuation_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/port_actuation_sequencer.sv
// Command FIFO for the sequencer: single-clock ring buffer with a flush and a look-ahead count.
// Latency: a pushed entry is visible at the head on the next cycle; a pop and a push may share a cycle.
// Backpressure: pushes are dropped when full (no push-through); flush drops everything.
module psq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic [W-1:0]           head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty    = (cnt == '0);
  assign do_push  = push_vld && (cnt != FULL_CNT) && !flush;
  assign do_pop   = pop_rdy && !empty && !flush;
  assign head_dat = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (flush)
      cnt_nxt = '0;
    else if (do_push && !do_pop)
      cnt_nxt = cnt + CNT_ONE;
    else if (!do_push && do_pop)
      cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Fluidic port sequencer: queues open/close commands and applies them one at a time to a registered port mask.
// Latency: push at edge t -> pop t+1, port_en update t+2, step_done at t+3+dwell.
// Backpressure: cmd_ready low while the FIFO is full, while abort is high and while rst is high.
module port_actuation_sequencer #(
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 8,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 3,
  parameter int DWELL_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ROW_W-1:0]             cmd_row,
  input  logic [COL_W-1:0]             cmd_col,
  input  logic                         cmd_open,
  input  logic [DWELL_W-1:0]           cmd_dwell,
  input  logic                         abort,
  output logic [NUM_ROWS*NUM_COLS-1:0] port_en,
  output logic                         busy,
  output logic                         step_done,
  output logic                         err_bad_port
);
  localparam int NUM_PORTS = NUM_ROWS * NUM_COLS;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, APPLY, DWELL} state_t;

  typedef struct packed {
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               is_open;
    logic [DWELL_W-1:0] dwell;
  } cmd_t;

  state_t               state;
  cmd_t                 cur;
  cmd_t                 push_cmd;
  cmd_t                 head_cmd;
  logic [DWELL_W-1:0]   cnt;
  logic                 done_pend;
  logic                 rdy_q;
  logic [NUM_PORTS-1:0] sel_mask;
  logic                 sel_ok;
  logic                 active_nxt;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_cnt_nxt;

  assign cmd_ready = rdy_q && !abort && !rst;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign push_cmd  = '{row: cmd_row, col: cmd_col, is_open: cmd_open, dwell: cmd_dwell};

  psq_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .push_vld (fifo_push),
    .push_dat (push_cmd),
    .pop_rdy  (fifo_pop),
    .head_dat (head_cmd),
    .empty    (fifo_empty),
    .cnt_nxt  (fifo_cnt_nxt)
  );

  // Out-of-range row/col decodes to an all-zero mask, which doubles as the bad-port flag.
  always_comb begin
    sel_mask = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        if (int'(cur.row) == r && int'(cur.col) == c)
          sel_mask[r*NUM_COLS + c] = 1'b1;
  end
  assign sel_ok = |sel_mask;

  // The step_done cycle still counts as busy so busy falls only after the pulse.
  assign active_nxt = (state != IDLE) || !fifo_empty || done_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur          <= '0;
      cnt          <= '0;
      port_en      <= '0;
      done_pend    <= 1'b0;
      step_done    <= 1'b0;
      err_bad_port <= 1'b0;
      busy         <= 1'b0;
      rdy_q        <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      cnt       <= '0;
      port_en   <= '0;
      done_pend <= 1'b0;
      step_done <= 1'b0;
      busy      <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      step_done <= done_pend;
      done_pend <= 1'b0;
      rdy_q     <= (fifo_cnt_nxt != FULL_CNT);
      busy      <= active_nxt || (fifo_cnt_nxt != '0);
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur   <= head_cmd;
            state <= APPLY;
          end
        end
        APPLY: begin
          if (sel_ok)
            port_en <= cur.is_open ? (port_en | sel_mask) : (port_en & ~sel_mask);
          else
            err_bad_port <= 1'b1;
          if (!sel_ok || cur.dwell == '0) begin
            done_pend <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt   <= cur.dwell;
            state <= DWELL;
          end
        end
        DWELL: begin
          cnt <= cnt - DWELL_W'(1);
          if (cnt == DWELL_W'(1)) begin
            done_pend <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
